// File: rtl/joy_db15_pkg.sv
// Shared constants and types for the DB15 joystick link device-side responder.
package joy_db15_pkg;

    localparam int FRAME_BITS_DEF  = 24;
    localparam int PLAYER_BITS_DEF = 12;

    // Button bit positions within each player's word.
    localparam int JB_R      = 0;
    localparam int JB_L      = 1;
    localparam int JB_D      = 2;
    localparam int JB_U      = 3;
    localparam int JB_A      = 4;
    localparam int JB_B      = 5;
    localparam int JB_C      = 6;
    localparam int JB_X      = 7;
    localparam int JB_Y      = 8;
    localparam int JB_Z      = 9;
    localparam int JB_START  = 10;
    localparam int JB_SELECT = 11;

    typedef enum logic {
        LOAD  = 1'b0,
        SHIFT = 1'b1
    } frame_state_t;

endpackage

// File: rtl/joy_db15_if.sv
// DB15 serial joystick link: poller (master) drives load/clock, device (slave) returns data.
interface joy_db15_if;
    // joy_load low = parallel capture, high = shift enabled; each joy_clk rising edge
    // advances one bit; joy_data is active-low and idles high. No flow control exists.
    logic joy_load;
    logic joy_clk;
    logic joy_data;

    modport master (output joy_load, output joy_clk, input joy_data);
    modport slave  (input joy_load, input joy_clk, output joy_data);
endinterface

// File: rtl/joy_db15_sync_edge.sv
// Two-flop synchroniser with a registered edge pulse (rising or falling, by parameter).
module sync_edge #(
    parameter bit RST_VAL     = 1'b0,
    parameter bit DETECT_RISE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic edge_pulse
);

    logic [1:0] sq;

    // The pulse is taken across the two stages so it lines up with sync_out changing,
    // which keeps pin-to-action latency at two cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq         <= {2{RST_VAL}};
            edge_pulse <= 1'b0;
        end else begin
            sq         <= {sq[0], async_in};
            edge_pulse <= DETECT_RISE ? (sq[0] & ~sq[1]) : (~sq[0] & sq[1]);
        end
    end

    assign sync_out = sq[1];

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick device-side responder: emulates the adapter's PISO shift-register chain.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int FRAME_BITS     = FRAME_BITS_DEF,
    parameter int PLAYER_BITS    = PLAYER_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                   clk,
    input  logic                   reset,
    joy_db15_if.slave              link,
    input  logic [PLAYER_BITS-1:0] joy1,
    input  logic [PLAYER_BITS-1:0] joy2,
    output logic                   frame_done,
    output logic [4:0]             bit_count,
    output logic                   link_active,
    output frame_state_t           frame_state
);

    localparam logic [4:0]  FB     = 5'(FRAME_BITS);
    localparam logic [4:0]  FB_M1  = 5'(FRAME_BITS - 1);
    localparam logic [19:0] TO     = 20'(TIMEOUT_CYCLES);
    localparam logic [19:0] TO_M1  = 20'(TIMEOUT_CYCLES - 1);

    logic                  load_s;
    logic                  load_fall;
    logic                  clk_s;
    logic                  clk_rise;
    logic [FRAME_BITS-1:0] sr;
    logic                  joy_data_q;
    logic                  loaded;
    logic [19:0]           wd_cnt;

    sync_edge #(.RST_VAL(1'b1), .DETECT_RISE(1'b0)) u_load_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (link.joy_load),
        .sync_out   (load_s),
        .edge_pulse (load_fall)
    );

    sync_edge #(.RST_VAL(1'b0), .DETECT_RISE(1'b1)) u_clk_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (link.joy_clk),
        .sync_out   (clk_s),
        .edge_pulse (clk_rise)
    );

    // Shifts only count once a frame has been captured since reset, so a joy_clk
    // that is already high when reset releases cannot advance an empty frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_state <= LOAD;
            sr          <= '1;
            joy_data_q  <= 1'b1;
            frame_done  <= 1'b0;
            bit_count   <= '0;
            loaded      <= 1'b0;
        end else begin
            joy_data_q <= sr[0];
            frame_done <= 1'b0;
            if (load_fall) loaded <= 1'b1;
            if (!load_s) begin
                frame_state <= LOAD;
                sr          <= ~{joy2, joy1};
                bit_count   <= '0;
            end else begin
                frame_state <= SHIFT;
                if (clk_rise && loaded) begin
                    sr <= {1'b1, sr[FRAME_BITS-1:1]};
                    if (bit_count != FB) begin
                        bit_count <= bit_count + 5'd1;
                        if (bit_count == FB_M1) frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            link_active <= 1'b0;
        end else if (load_fall) begin
            wd_cnt      <= '0;
            link_active <= 1'b1;
        end else if (wd_cnt != TO) begin
            wd_cnt <= wd_cnt + 20'd1;
            if (wd_cnt == TO_M1) link_active <= 1'b0;
        end
    end

    assign link.joy_data = joy_data_q;

    // clk_s is kept for observability in simulation hierarchies; it drives nothing here.
    logic unused_clk_s;
    assign unused_clk_s = clk_s;

endmodule
